// File: rtl/lc3_mmio_kbd_dsp_if.sv
// CPU-side MMIO bus plus keyboard/display device handshakes for the LC-3
// keyboard/display controller. The master side is the CPU and the devices.
// The slave side is the controller.
interface lc3_mmio_kbd_dsp_if;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic        IO_RD;
  logic        IO_WR;
  logic        IO_SEL;
  logic [15:0] IO_RD_DATA;
  logic        IO_RD_VALID;
  logic        KBD_VALID;
  logic [7:0]  KBD_DATA;
  logic        KBD_READY;
  logic        DSP_VALID;
  logic [7:0]  DSP_DATA;
  logic        DSP_READY;
  logic        INT_REQ;

  modport master (
    output MAR_OUT, MDR_OUT, IO_RD, IO_WR, KBD_VALID, KBD_DATA, DSP_READY,
    input  IO_SEL, IO_RD_DATA, IO_RD_VALID, KBD_READY, DSP_VALID, DSP_DATA, INT_REQ
  );

  modport slave (
    input  MAR_OUT, MDR_OUT, IO_RD, IO_WR, KBD_VALID, KBD_DATA, DSP_READY,
    output IO_SEL, IO_RD_DATA, IO_RD_VALID, KBD_READY, DSP_VALID, DSP_DATA, INT_REQ
  );
endinterface

// File: rtl/lc3_mmio_kbd_dsp.sv
// LC-3 memory-mapped keyboard/display controller with FIFO-buffered channels.
// KBSR/KBDR/DSR/DDR sit beside memory on the MAR/MDR path; IO_SEL steers the
// MIO mux. Reads have one cycle of latency.
// Optional build macro: LC3_KBD_INT_EN enables the KBSR interrupt-enable bit
// and a registered keyboard interrupt request. Without it, IE reads 0,
// KBSR writes are ignored and INT_REQ is tied low.
module lc3_mmio_kbd_dsp #(
  parameter int          KBD_DEPTH = 4,
  parameter int          DSP_DEPTH = 4,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  lc3_mmio_kbd_dsp_if.slave bus
);

  localparam int KW = $clog2(KBD_DEPTH);
  localparam int DW = $clog2(DSP_DEPTH);

  localparam logic [KW:0]   KBD_FULL = (KW+1)'(KBD_DEPTH);
  localparam logic [KW:0]   KCNT_ONE = (KW+1)'(1);
  localparam logic [KW-1:0] KPTR_ONE = KW'(1);
  localparam logic [DW:0]   DSP_FULL = (DW+1)'(DSP_DEPTH);
  localparam logic [DW:0]   DCNT_ONE = (DW+1)'(1);
  localparam logic [DW-1:0] DPTR_ONE = DW'(1);

  // LC-3 status layout: bit 15 = ready/nonempty, bit 14 = interrupt enable.
  function automatic logic [15:0] status_word(input logic flag_rdy,
                                              input logic flag_ie);
    return {flag_rdy, flag_ie, 14'b0};
  endfunction

  // Address decode and strobe qualification
  logic w_sel_kbsr, w_sel_kbdr, w_sel_dsr, w_sel_ddr, w_io_sel;
  logic w_rd_acc, w_wr_acc;

  // Keyboard FIFO
  logic [7:0]    r_kbd_mem [KBD_DEPTH];
  logic [KW-1:0] r_kbd_wp, r_kbd_rp;
  logic [KW:0]   r_kbd_cnt;
  logic          w_kbd_nonempty, w_kbd_ready, w_kbd_push, w_kbd_pop;

  // Display FIFO and DDR shadow
  logic [7:0]    r_dsp_mem [DSP_DEPTH];
  logic [DW-1:0] r_dsp_wp, r_dsp_rp;
  logic [DW:0]   r_dsp_cnt;
  logic          w_dsp_nonempty, w_dsp_not_full, w_dsp_push, w_dsp_pop;
  logic [15:0]   r_ddr_shadow;

  // Read path
  logic [15:0]   w_rd_word;
  logic [15:0]   r_rd_data_p1;
  logic          r_rd_vld_p1;

  // Interrupt enable as seen by the KBSR read mux
  logic          w_ie;

  // Decode the four register addresses from the CPU address
  always_comb begin
    w_sel_kbsr = (bus.MAR_OUT == KBSR_ADDR);
    w_sel_kbdr = (bus.MAR_OUT == KBDR_ADDR);
    w_sel_dsr  = (bus.MAR_OUT == DSR_ADDR);
    w_sel_ddr  = (bus.MAR_OUT == DDR_ADDR);
    w_io_sel   = w_sel_kbsr | w_sel_kbdr | w_sel_dsr | w_sel_ddr;
    // A read in the same cycle as a write wins; the write is discarded.
    w_rd_acc   = bus.IO_RD & w_io_sel;
    w_wr_acc   = bus.IO_WR & w_io_sel & ~bus.IO_RD;
  end

  assign w_kbd_nonempty = (r_kbd_cnt != '0);
  assign w_kbd_ready    = (r_kbd_cnt < KBD_FULL);
  assign w_kbd_push     = bus.KBD_VALID & w_kbd_ready;
  // Pop uses the pre-edge count, so a KBDR read racing a push into an empty
  // FIFO returns 0 and leaves the new byte in place.
  assign w_kbd_pop      = w_rd_acc & w_sel_kbdr & w_kbd_nonempty;

  assign w_dsp_nonempty = (r_dsp_cnt != '0);
  assign w_dsp_not_full = (r_dsp_cnt < DSP_FULL);
  assign w_dsp_push     = w_wr_acc & w_sel_ddr & w_dsp_not_full;
  assign w_dsp_pop      = w_dsp_nonempty & bus.DSP_READY;

  // Keyboard FIFO storage write at the tail
  always_ff @(posedge i_Clk) begin
    if (w_kbd_push) r_kbd_mem[r_kbd_wp] <= bus.KBD_DATA;
  end

  // Keyboard FIFO pointers and occupancy
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_kbd_wp  <= '0;
      r_kbd_rp  <= '0;
      r_kbd_cnt <= '0;
    end else begin
      if (w_kbd_push) r_kbd_wp <= r_kbd_wp + KPTR_ONE;
      if (w_kbd_pop)  r_kbd_rp <= r_kbd_rp + KPTR_ONE;
      case ({w_kbd_push, w_kbd_pop})
        2'b10:   r_kbd_cnt <= r_kbd_cnt + KCNT_ONE;
        2'b01:   r_kbd_cnt <= r_kbd_cnt - KCNT_ONE;
        default: r_kbd_cnt <= r_kbd_cnt;
      endcase
    end
  end

  // Display FIFO storage write at the tail
  always_ff @(posedge i_Clk) begin
    if (w_dsp_push) r_dsp_mem[r_dsp_wp] <= bus.MDR_OUT[7:0];
  end

  // Display FIFO pointers, occupancy and DDR shadow (dropped writes leave it)
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_dsp_wp     <= '0;
      r_dsp_rp     <= '0;
      r_dsp_cnt    <= '0;
      r_ddr_shadow <= 16'h0000;
    end else begin
      if (w_dsp_push) begin
        r_dsp_wp     <= r_dsp_wp + DPTR_ONE;
        r_ddr_shadow <= bus.MDR_OUT;
      end
      if (w_dsp_pop) r_dsp_rp <= r_dsp_rp + DPTR_ONE;
      case ({w_dsp_push, w_dsp_pop})
        2'b10:   r_dsp_cnt <= r_dsp_cnt + DCNT_ONE;
        2'b01:   r_dsp_cnt <= r_dsp_cnt - DCNT_ONE;
        default: r_dsp_cnt <= r_dsp_cnt;
      endcase
    end
  end

  // Select the register value addressed by the current read
  always_comb begin
    w_rd_word = 16'h0000;
    if (w_sel_kbsr)
      w_rd_word = status_word(w_kbd_nonempty, w_ie);
    else if (w_sel_kbdr)
      w_rd_word = w_kbd_nonempty ? {8'h00, r_kbd_mem[r_kbd_rp]} : 16'h0000;
    else if (w_sel_dsr)
      w_rd_word = status_word(w_dsp_not_full, 1'b0);
    else if (w_sel_ddr)
      w_rd_word = r_ddr_shadow;
  end

  // ---- stage p1: registered read data and its valid pulse ----
  // Capture read data on accepted reads; data holds between reads
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_rd_data_p1 <= 16'h0000;
      r_rd_vld_p1  <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_acc;
      if (w_rd_acc) r_rd_data_p1 <= w_rd_word;
    end
  end

`ifdef LC3_KBD_INT_EN
  logic r_ie;
  logic r_int_req;

  // IE loads from MDR bit 14 on KBSR writes; INT_REQ trails the state by a cycle
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ie      <= 1'b0;
      r_int_req <= 1'b0;
    end else begin
      if (w_wr_acc & w_sel_kbsr) r_ie <= bus.MDR_OUT[14];
      r_int_req <= r_ie & w_kbd_nonempty;
    end
  end

  assign w_ie        = r_ie;
  assign bus.INT_REQ = r_int_req;
`else
  assign w_ie        = 1'b0;
  assign bus.INT_REQ = 1'b0;
`endif

  assign bus.IO_SEL      = w_io_sel;
  assign bus.IO_RD_DATA  = r_rd_data_p1;
  assign bus.IO_RD_VALID = r_rd_vld_p1;
  assign bus.KBD_READY   = w_kbd_ready;
  assign bus.DSP_VALID   = w_dsp_nonempty;
  assign bus.DSP_DATA    = r_dsp_mem[r_dsp_rp];

endmodule

// File: tb/tb_lc3_mmio_kbd_dsp.sv
// Bench for lc3_mmio_kbd_dsp: directed scenarios plus randomized traffic
// compared against a queue-based register-level model.
`timescale 1ns/1ps
module tb_lc3_mmio_kbd_dsp;
  localparam int KD = 4;
  localparam int DD = 4;
  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;
`ifdef LC3_KBD_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_mmio_kbd_dsp_if bus();

  lc3_mmio_kbd_dsp #(.KBD_DEPTH(KD), .DSP_DEPTH(DD)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus.slave)
  );

  int errs = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  kq[$];
  logic [7:0]  dq[$];
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_rd_data = 16'h0;
  bit          m_rd_vld = 1'b0;
  bit          m_ie = 1'b0;
  bit          m_int = 1'b0;

  function automatic bit is_reg(input logic [15:0] a);
    return (a == A_KBSR) || (a == A_KBDR) || (a == A_DSR) || (a == A_DDR);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_edge();
    logic [15:0] a;
    logic [15:0] w;
    bit rd, wr, kpush, kpop, dpush, dpop, nxt_int;
    a = bus.MAR_OUT;
    if (rst) begin
      kq.delete(); dq.delete();
      m_shadow = 0; m_rd_data = 0; m_rd_vld = 0; m_ie = 0; m_int = 0;
      return;
    end
    rd      = bus.IO_RD && is_reg(a);
    wr      = bus.IO_WR && is_reg(a) && !bus.IO_RD;
    kpush   = bus.KBD_VALID && (kq.size() < KD);
    kpop    = rd && (a == A_KBDR) && (kq.size() > 0);
    dpop    = bus.DSP_READY && (dq.size() > 0);
    dpush   = wr && (a == A_DDR) && (dq.size() < DD);
    nxt_int = INT_EN && m_ie && (kq.size() > 0);
    w = 16'h0;
    if (a == A_KBSR)      w = {kq.size() > 0, m_ie, 14'b0};
    else if (a == A_KBDR) w = (kq.size() > 0) ? {8'h00, kq[0]} : 16'h0;
    else if (a == A_DSR)  w = {dq.size() < DD, 15'b0};
    else if (a == A_DDR)  w = m_shadow;
    m_rd_vld = rd;
    if (rd) m_rd_data = w;
    if (kpop)  void'(kq.pop_front());
    if (kpush) kq.push_back(bus.KBD_DATA);
    if (dpop)  void'(dq.pop_front());
    if (dpush) begin
      dq.push_back(bus.MDR_OUT[7:0]);
      m_shadow = bus.MDR_OUT;
    end
    if (wr && (a == A_KBSR) && INT_EN) m_ie = bus.MDR_OUT[14];
    m_int = nxt_int;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    bus.MAR_OUT = a; bus.IO_RD = 1'b1;
    tick();
    bus.IO_RD = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    bus.MAR_OUT = a; bus.MDR_OUT = d; bus.IO_WR = 1'b1;
    tick();
    bus.IO_WR = 1'b0;
  endtask

  task automatic kbd_push(input logic [7:0] b);
    bus.KBD_VALID = 1'b1; bus.KBD_DATA = b;
    tick();
    bus.KBD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.IO_RD_VALID !== 1'b0) begin errs++; $display("FAIL rst_vld got=%b exp=0", bus.IO_RD_VALID); end
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL rst_data got=%h exp=0000", bus.IO_RD_DATA); end
    checks++; if (bus.DSP_VALID !== 1'b0) begin errs++; $display("FAIL rst_dsp_valid got=%b exp=0", bus.DSP_VALID); end
    checks++; if (bus.KBD_READY !== 1'b1) begin errs++; $display("FAIL rst_kbd_ready got=%b exp=1", bus.KBD_READY); end
    checks++; if (bus.INT_REQ !== 1'b0) begin errs++; $display("FAIL rst_int got=%b exp=0", bus.INT_REQ); end
    cpu_rd(A_KBSR);
    checks++; if (bus.IO_RD_VALID !== 1'b1) begin errs++; $display("FAIL kbsr_vld got=%b exp=1", bus.IO_RD_VALID); end
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL kbsr_empty got=%h exp=0000", bus.IO_RD_DATA); end
    cpu_rd(A_DSR);
    checks++; if (bus.IO_RD_DATA !== 16'h8000) begin errs++; $display("FAIL dsr_empty got=%h exp=8000", bus.IO_RD_DATA); end
  endtask

  task automatic test_kbd_basic();
    bus.MAR_OUT = A_DDR; #1;
    checks++; if (bus.IO_SEL !== 1'b1) begin errs++; $display("FAIL io_sel_hit got=%b exp=1", bus.IO_SEL); end
    bus.MAR_OUT = 16'hFE01; #1;
    checks++; if (bus.IO_SEL !== 1'b0) begin errs++; $display("FAIL io_sel_miss got=%b exp=0", bus.IO_SEL); end
    cpu_rd(16'hFE08);
    checks++; if (bus.IO_RD_VALID !== 1'b0) begin errs++; $display("FAIL unsel_rd_vld got=%b exp=0", bus.IO_RD_VALID); end
    kbd_push(8'h41);
    kbd_push(8'h42);
    cpu_rd(A_KBSR);
    checks++; if (bus.IO_RD_DATA !== 16'h8000) begin errs++; $display("FAIL kbsr_ready got=%h exp=8000", bus.IO_RD_DATA); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0041) begin errs++; $display("FAIL kbdr_A got=%h exp=0041", bus.IO_RD_DATA); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0042) begin errs++; $display("FAIL kbdr_B got=%h exp=0042", bus.IO_RD_DATA); end
    cpu_rd(A_KBSR);
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL kbsr_drained got=%h exp=0000", bus.IO_RD_DATA); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL kbdr_empty got=%h exp=0000", bus.IO_RD_DATA); end
    checks++; if (bus.IO_RD_VALID !== 1'b1) begin errs++; $display("FAIL kbdr_empty_vld got=%b exp=1", bus.IO_RD_VALID); end
  endtask

  task automatic test_kbd_full();
    for (int i = 0; i < 4; i++) kbd_push(8'(8'h10 + i));
    checks++; if (bus.KBD_READY !== 1'b0) begin errs++; $display("FAIL kbd_full_ready got=%b exp=0", bus.KBD_READY); end
    bus.KBD_VALID = 1'b1; bus.KBD_DATA = 8'h14;
    tick();
    checks++; if (bus.KBD_READY !== 1'b0) begin errs++; $display("FAIL kbd_held_ready got=%b exp=0", bus.KBD_READY); end
    bus.MAR_OUT = A_KBDR; bus.IO_RD = 1'b1;
    tick();
    bus.IO_RD = 1'b0;
    checks++; if (bus.IO_RD_DATA !== 16'h0010) begin errs++; $display("FAIL kbd_full_pop got=%h exp=0010", bus.IO_RD_DATA); end
    checks++; if (bus.KBD_READY !== 1'b1) begin errs++; $display("FAIL kbd_after_pop_ready got=%b exp=1", bus.KBD_READY); end
    tick();
    bus.KBD_VALID = 1'b0;
    checks++; if (bus.KBD_READY !== 1'b0) begin errs++; $display("FAIL kbd_refill_ready got=%b exp=0", bus.KBD_READY); end
    for (int i = 1; i < 5; i++) begin
      cpu_rd(A_KBDR);
      checks++; if (bus.IO_RD_DATA !== 16'(16'h0010 + i)) begin errs++; $display("FAIL kbd_order%0d got=%h exp=%h", i, bus.IO_RD_DATA, 16'(16'h0010 + i)); end
    end
  endtask

  task automatic test_dsp_full();
    bus.DSP_READY = 1'b0;
    for (int i = 0; i < 4; i++) cpu_wr(A_DDR, 16'(16'h0031 + i));
    cpu_rd(A_DSR);
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL dsr_full got=%h exp=0000", bus.IO_RD_DATA); end
    cpu_wr(A_DDR, 16'h0035);
    cpu_rd(A_DDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0034) begin errs++; $display("FAIL ddr_shadow_drop got=%h exp=0034", bus.IO_RD_DATA); end
    bus.DSP_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.DSP_VALID !== 1'b1 || bus.DSP_DATA !== 8'(8'h31 + i)) begin errs++; $display("FAIL dsp_drain%0d got=%b/%h exp=1/%h", i, bus.DSP_VALID, bus.DSP_DATA, 8'(8'h31 + i)); end
      tick();
    end
    checks++; if (bus.DSP_VALID !== 1'b0) begin errs++; $display("FAIL dsp_empty got=%b exp=0", bus.DSP_VALID); end
    bus.DSP_READY = 1'b0;
  endtask

  task automatic test_same_cycle();
    kbd_push(8'h55);
    bus.MAR_OUT = A_KBDR; bus.IO_RD = 1'b1; bus.KBD_VALID = 1'b1; bus.KBD_DATA = 8'h66;
    tick();
    bus.IO_RD = 1'b0; bus.KBD_VALID = 1'b0;
    checks++; if (bus.IO_RD_DATA !== 16'h0055) begin errs++; $display("FAIL pushpop_old got=%h exp=0055", bus.IO_RD_DATA); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0066) begin errs++; $display("FAIL pushpop_new got=%h exp=0066", bus.IO_RD_DATA); end
    bus.MAR_OUT = A_KBDR; bus.IO_RD = 1'b1; bus.KBD_VALID = 1'b1; bus.KBD_DATA = 8'h77;
    tick();
    bus.IO_RD = 1'b0; bus.KBD_VALID = 1'b0;
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL empty_race got=%h exp=0000", bus.IO_RD_DATA); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0077) begin errs++; $display("FAIL empty_race_kept got=%h exp=0077", bus.IO_RD_DATA); end
    bus.MAR_OUT = A_DDR; bus.MDR_OUT = 16'h0099; bus.IO_RD = 1'b1; bus.IO_WR = 1'b1;
    tick();
    bus.IO_RD = 1'b0; bus.IO_WR = 1'b0;
    checks++; if (bus.IO_RD_DATA !== 16'h0034) begin errs++; $display("FAIL rdwr_read got=%h exp=0034", bus.IO_RD_DATA); end
    checks++; if (bus.DSP_VALID !== 1'b0) begin errs++; $display("FAIL rdwr_nowrite got=%b exp=0", bus.DSP_VALID); end
  endtask

  task automatic test_mid_reset();
    kbd_push(8'h01);
    kbd_push(8'h02);
    cpu_wr(A_DDR, 16'h1277);
    rst = 1'b1; bus.MAR_OUT = A_KBSR; bus.IO_RD = 1'b1; bus.KBD_VALID = 1'b1; bus.KBD_DATA = 8'h33;
    tick();
    rst = 1'b0; bus.IO_RD = 1'b0; bus.KBD_VALID = 1'b0;
    checks++; if (bus.IO_RD_VALID !== 1'b0 || bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL midrst_rd got=%b/%h exp=0/0000", bus.IO_RD_VALID, bus.IO_RD_DATA); end
    checks++; if (bus.DSP_VALID !== 1'b0 || bus.KBD_READY !== 1'b1) begin errs++; $display("FAIL midrst_fifo got=%b/%b exp=0/1", bus.DSP_VALID, bus.KBD_READY); end
    cpu_rd(A_KBSR);
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL midrst_kbsr got=%h exp=0000", bus.IO_RD_DATA); end
    cpu_rd(A_DDR);
    checks++; if (bus.IO_RD_DATA !== 16'h0000) begin errs++; $display("FAIL midrst_shadow got=%h exp=0000", bus.IO_RD_DATA); end
  endtask

  task automatic test_int();
    cpu_wr(A_KBSR, 16'h4000);
    cpu_rd(A_KBSR);
    checks++; if (bus.IO_RD_DATA !== (INT_EN ? 16'h4000 : 16'h0000)) begin errs++; $display("FAIL ie_readback got=%h exp=%h", bus.IO_RD_DATA, INT_EN ? 16'h4000 : 16'h0000); end
    kbd_push(8'h5A);
    checks++; if (bus.INT_REQ !== 1'b0) begin errs++; $display("FAIL int_lag got=%b exp=0", bus.INT_REQ); end
    tick();
    checks++; if (bus.INT_REQ !== INT_EN) begin errs++; $display("FAIL int_raise got=%b exp=%b", bus.INT_REQ, INT_EN); end
    cpu_rd(A_KBDR);
    checks++; if (bus.IO_RD_DATA !== 16'h005A || bus.INT_REQ !== INT_EN) begin errs++; $display("FAIL int_pop got=%h/%b exp=005a/%b", bus.IO_RD_DATA, bus.INT_REQ, INT_EN); end
    tick();
    checks++; if (bus.INT_REQ !== 1'b0) begin errs++; $display("FAIL int_drop got=%b exp=0", bus.INT_REQ); end
    kbd_push(8'h5B);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.INT_REQ !== 1'b0) begin errs++; $display("FAIL int_reset got=%b exp=0", bus.INT_REQ); end
    kbd_push(8'h5C);
    tick();
    checks++; if (bus.INT_REQ !== 1'b0) begin errs++; $display("FAIL int_ie_cleared got=%b exp=0", bus.INT_REQ); end
    cpu_rd(A_KBDR);
  endtask

  task automatic test_random();
    logic [15:0] addrs [4];
    bit exp_sel;
    addrs[0] = A_KBSR; addrs[1] = A_KBDR; addrs[2] = A_DSR; addrs[3] = A_DDR;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(4) != 0) bus.MAR_OUT = addrs[$urandom_range(3)];
      else                        bus.MAR_OUT = 16'($urandom);
      bus.MDR_OUT   = 16'($urandom);
      bus.IO_RD     = ($urandom_range(2) == 0);
      bus.IO_WR     = ($urandom_range(1) == 0);
      bus.KBD_VALID = ($urandom_range(1) == 0);
      bus.KBD_DATA  = 8'($urandom);
      bus.DSP_READY = ($urandom_range(2) == 0);
      #1;
      exp_sel = is_reg(bus.MAR_OUT);
      checks++; if (bus.IO_SEL !== exp_sel) begin errs++; $display("FAIL rnd_sel n=%0d got=%b exp=%b", n, bus.IO_SEL, exp_sel); end
      tick();
      checks++; if (bus.IO_RD_VALID !== m_rd_vld) begin errs++; $display("FAIL rnd_vld n=%0d got=%b exp=%b", n, bus.IO_RD_VALID, m_rd_vld); end
      checks++; if (bus.IO_RD_DATA !== m_rd_data) begin errs++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus.IO_RD_DATA, m_rd_data); end
      checks++; if (bus.KBD_READY !== (kq.size() < KD)) begin errs++; $display("FAIL rnd_kbd_ready n=%0d got=%b exp=%b", n, bus.KBD_READY, kq.size() < KD); end
      checks++; if (bus.DSP_VALID !== (dq.size() > 0)) begin errs++; $display("FAIL rnd_dsp_valid n=%0d got=%b exp=%b", n, bus.DSP_VALID, dq.size() > 0); end
      if (dq.size() > 0) begin
        checks++; if (bus.DSP_DATA !== dq[0]) begin errs++; $display("FAIL rnd_dsp_data n=%0d got=%h exp=%h", n, bus.DSP_DATA, dq[0]); end
      end
      checks++; if (bus.INT_REQ !== m_int) begin errs++; $display("FAIL rnd_int n=%0d got=%b exp=%b", n, bus.INT_REQ, m_int); end
    end
    rst = 1'b0; bus.IO_RD = 1'b0; bus.IO_WR = 1'b0; bus.KBD_VALID = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.MAR_OUT = 16'h0; bus.MDR_OUT = 16'h0;
    bus.IO_RD = 1'b0; bus.IO_WR = 1'b0;
    bus.KBD_VALID = 1'b0; bus.KBD_DATA = 8'h0;
    bus.DSP_READY = 1'b0;
    test_reset();
    test_kbd_basic();
    test_kbd_full();
    test_dsp_full();
    test_same_cycle();
    test_mid_reset();
    test_int();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
